ts_pid_demux: RTL and testbench

//  Receive end of the 4-channel TS mux: takes the single muxed MPEG2-TS byte stream, finds and

---
 rtl/ts_pid_demux.sv | 215 +++++++++++++++++++++
 tb/tb_ts_pid_demux.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ts_pid_demux.sv
// ts_pid_demux: receive side of the 4-channel TS mux.
// Locks to 188-byte packet sync, routes each packet by PID.
module ts_pid_demux #(
  parameter int LOCK_PKTS = 2,
  parameter bit DROP_TEI  = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  input  logic [51:0]      pid_cfg,
  input  logic [3:0]       pid_en,
  output logic [7:0]       data_out,
  output logic [3:0]       valid_out,
  output logic             sop_out,
  output logic             locked,
  output logic [CNT_W-1:0] sync_err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } st_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  st_t        st_q, st_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] good_q, good_d;
  logic [7:0] good_nx;
  logic       is_sync;
  logic       at0;
  logic       lock_hit;

  logic       tag_in;
  logic       tag_sop;
  logic       sync_loss;

  logic [7:0] dl_d [3];
  logic       dl_in [3];
  logic       dl_sop [3];

  logic       pend_fwd, act_fwd;
  logic [1:0] pend_ch, act_ch;

  logic [12:0] pid;
  logic        hit;
  logic [1:0]  hit_ch;
  logic        fwd_c;
  logic        dec;

  logic        use_fwd;
  logic [1:0]  use_ch;
  logic [3:0]  vo_c;

  assign is_sync  = (data_in == 8'h47);
  assign at0      = (idx_q == 8'd0);
  assign good_nx  = good_q + 8'd1;
  assign lock_hit = (int'(good_nx) >= LOCK_PKTS);
  assign locked   = (st_q == LOCKED);

  // Sync FSM state, byte index and good-sync count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= HUNT;
      idx_q  <= 8'd0;
      good_q <= 8'd0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      good_q <= good_d;
    end
  end

  // Next state; a bad LOCKED sync byte is not 0x47, so as a
  // HUNT byte it simply leaves the FSM hunting at index 0.
  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    good_d = good_q;
    if (valid_in) begin
      idx_d = (idx_q == 8'd187) ? 8'd0 : idx_q + 8'd1;
      unique case (st_q)
        HUNT: begin
          if (is_sync) begin
            st_d   = VERIFY;
            good_d = 8'd1;
            idx_d  = 8'd1;
          end else begin
            idx_d = 8'd0;
          end
        end
        VERIFY: begin
          if (at0) begin
            if (is_sync) begin
              good_d = good_nx;
              if (lock_hit) st_d = LOCKED;
            end else begin
              st_d   = HUNT;
              idx_d  = 8'd0;
              good_d = 8'd0;
            end
          end
        end
        LOCKED: begin
          if (at0 && !is_sync) begin
            st_d   = HUNT;
            idx_d  = 8'd0;
            good_d = 8'd0;
          end
        end
        default: begin
          st_d   = HUNT;
          idx_d  = 8'd0;
          good_d = 8'd0;
        end
      endcase
    end
  end

  // Per-byte tags: in-packet, start-of-packet, sync loss.
  always_comb begin
    tag_in    = 1'b0;
    tag_sop   = 1'b0;
    sync_loss = 1'b0;
    if (valid_in) begin
      tag_in    = (st_d == LOCKED);
      tag_sop   = tag_in && at0;
      sync_loss = (st_q == LOCKED) && at0 && !is_sync;
    end
  end

  assign pid = {dl_d[0][4:0], data_in};
  assign dec = valid_in && (idx_q == 8'd2);

  // PID lookup; lowest enabled matching channel wins.
  always_comb begin
    hit    = 1'b0;
    hit_ch = 2'd0;
    for (int n = 3; n >= 0; n--) begin
      if (pid_en[n] && (pid_cfg[13*n +: 13] == pid)) begin
        hit    = 1'b1;
        hit_ch = 2'(n);
      end
    end
    fwd_c = hit && !(DROP_TEI && dl_d[0][7]);
  end

  // Route for the byte leaving the delay line.
  always_comb begin
    use_fwd = dl_sop[2] ? pend_fwd : act_fwd;
    use_ch  = dl_sop[2] ? pend_ch : act_ch;
    vo_c    = (dl_in[2] && use_fwd) ? (4'b0001 << use_ch) : 4'b0000;
  end

  // Delay line, route registers and output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        dl_d[i]   <= 8'd0;
        dl_in[i]  <= 1'b0;
        dl_sop[i] <= 1'b0;
      end
      pend_fwd  <= 1'b0;
      pend_ch   <= 2'd0;
      act_fwd   <= 1'b0;
      act_ch    <= 2'd0;
      data_out  <= 8'd0;
      valid_out <= 4'd0;
      sop_out   <= 1'b0;
    end else begin
      valid_out <= 4'd0;
      sop_out   <= 1'b0;
      if (valid_in) begin
        dl_d[0]   <= data_in;
        dl_in[0]  <= tag_in;
        dl_sop[0] <= tag_sop;
        for (int i = 1; i < 3; i++) begin
          dl_d[i]   <= dl_d[i-1];
          dl_in[i]  <= dl_in[i-1];
          dl_sop[i] <= dl_sop[i-1];
        end
        data_out  <= dl_d[2];
        valid_out <= vo_c;
        sop_out   <= dl_sop[2] && (vo_c != 4'd0);
        if (dec) begin
          pend_fwd <= fwd_c;
          pend_ch  <= hit_ch;
        end
        if (dl_sop[2]) begin
          act_fwd <= pend_fwd;
          act_ch  <= pend_ch;
        end
      end
    end
  end

  // Saturating sync-loss and dropped-packet counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (sync_loss && sync_err_cnt != CNT_MAX)
        sync_err_cnt <= sync_err_cnt + CNT_ONE;
      if (valid_in && dl_sop[2] && !pend_fwd && drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ts_pid_demux.sv
// tb_ts_pid_demux: scoreboard bench for ts_pid_demux.
// Directed packet table, run gapless and then with random gaps.
module tb_ts_pid_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        valid_in = 1'b0;
  logic [51:0] pid_cfg;
  logic [3:0]  pid_en = 4'b1111;
  logic [7:0]  data_out;
  logic [3:0]  valid_out;
  logic        sop_out;
  logic        locked;
  logic [15:0] sync_err_cnt;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [7:0] d;
    logic [3:0] v;
    logic       s;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   sent = 0;
  int   acc = 0;
  bit   pv = 1'b0;
  bit   gaps = 1'b0;

  ts_pid_demux #(
    .LOCK_PKTS(2),
    .DROP_TEI(1'b1),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .valid_in(valid_in),
    .pid_cfg(pid_cfg),
    .pid_en(pid_en),
    .data_out(data_out),
    .valid_out(valid_out),
    .sop_out(sop_out),
    .locked(locked),
    .sync_err_cnt(sync_err_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: pop one expected byte per DUT output beat.
  always @(negedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      acc = 0;
      pv  = 1'b0;
    end else begin
      acc += int'(pv);
      if (valid_out != 4'd0 || sop_out) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got d=%h v=%b s=%b want nothing",
                   data_out, valid_out, sop_out);
        end else begin
          e = q.pop_front();
          if (data_out !== e.d || valid_out !== e.v ||
              sop_out !== e.s || acc != e.idx + 4) begin
            n_err++;
            $display("FAIL out_byte: got d=%h v=%b s=%b beat=%0d want d=%h v=%b s=%b beat=%0d",
                     data_out, valid_out, sop_out, acc,
                     e.d, e.v, e.s, e.idx + 4);
          end
        end
      end
      pv = valid_in;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pay(input int pn, input int k);
    logic [7:0] b;
    b = 8'((k * 3 + pn * 11) & 255);
    if (b == 8'h47) b = 8'h48;
    return b;
  endfunction

  task automatic beat(input logic [7:0] b);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        valid_in = 1'b0;
        data_in  = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
      end
    end
    data_in  = b;
    valid_in = 1'b1;
    sent++;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int pn, input logic [12:0] pid,
                          input logic tei, input logic [7:0] sb,
                          input logic [3:0] m, input int n,
                          input int el);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      if (k == 0) b = sb;
      else if (k == 1) b = {tei, 2'b00, pid[12:8]};
      else if (k == 2) b = pid[7:0];
      else b = pay(pn, k);
      if (m != 4'd0) q.push_back('{d: b, v: m, s: (k == 0), idx: sent});
      beat(b);
      if (k == 0 && el >= 0) chk($sformatf("locked_p%0d", pn), int'(locked), el);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_data"}, int'(data_out), 0);
    chk({nm, "_valid"}, int'(valid_out), 0);
    chk({nm, "_sop"}, int'(sop_out), 0);
    chk({nm, "_locked"}, int'(locked), 0);
    chk({nm, "_serr"}, int'(sync_err_cnt), 0);
    chk({nm, "_drop"}, int'(drop_cnt), 0);
  endtask

  task automatic run_seq(input string tag);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    q.delete();
    sent     = 0;
    pid_en   = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs({tag, "_rst"});
    rst_n = 1'b1;
    send_pkt(0, 13'h100, 1'b0, 8'h47, 4'b0000, 188, 0);
    send_pkt(1, 13'h100, 1'b0, 8'h47, 4'b0100, 188, 1);
    send_pkt(2, 13'h100, 1'b0, 8'h47, 4'b0100, 188, -1);
    send_pkt(3, 13'h020, 1'b0, 8'h47, 4'b0001, 188, -1);
    send_pkt(4, 13'h030, 1'b0, 8'h47, 4'b0010, 188, -1);
    send_pkt(5, 13'h040, 1'b0, 8'h47, 4'b0000, 188, -1);
    chk({tag, "_drop_nohit"}, int'(drop_cnt), 1);
    send_pkt(6, 13'h020, 1'b1, 8'h47, 4'b0000, 188, -1);
    chk({tag, "_drop_tei"}, int'(drop_cnt), 2);
    send_pkt(7, 13'h020, 1'b0, 8'h47, 4'b0001, 188, -1);
    send_pkt(8, 13'h100, 1'b0, 8'h46, 4'b0000, 188, 0);
    chk({tag, "_serr"}, int'(sync_err_cnt), 1);
    send_pkt(9, 13'h100, 1'b0, 8'h47, 4'b0000, 188, 0);
    send_pkt(10, 13'h100, 1'b0, 8'h47, 4'b0100, 188, 1);
    pid_en = 4'b1110;
    send_pkt(11, 13'h020, 1'b0, 8'h47, 4'b1000, 188, -1);
    send_pkt(12, 13'h100, 1'b0, 8'h47, 4'b0100, 90, -1);
    chk({tag, "_drop_end"}, int'(drop_cnt), 2);
    chk({tag, "_serr_end"}, int'(sync_err_cnt), 1);
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_inflight"}, q.size(), 3);
    rst_n = 1'b0;
    q.delete();
    sent = 0;
    #1;
    chk_reset_outs({tag, "_midrst"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pkt(13, 13'h030, 1'b0, 8'h47, 4'b0000, 188, 0);
    send_pkt(14, 13'h030, 1'b0, 8'h47, 4'b0010, 188, 1);
    send_pkt(15, 13'h100, 1'b0, 8'h47, 4'b0000, 3, -1);
    chk({tag, "_relock_drop"}, int'(drop_cnt), 0);
    valid_in = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    pid_cfg = {13'h020, 13'h100, 13'h030, 13'h020};
    gaps = 1'b0;
    run_seq("nogap");
    gaps = 1'b1;
    run_seq("gap");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
